// File: rtl/battleship_disp_ctrl.sv
// battleship_disp_ctrl
// Turns the game FSM's per-player status codes into two-character messages
// and scans them onto the 4-digit seven-segment display. The left pair of
// digits shows player A and the right pair shows player B. An error code
// (5) is held on screen for at least ERR_HOLD cycles, so a one-cycle Redo
// state is still visible.
//
// Optional feature macro: BSDISP_BLINK_EN
//   defined   - code 1 ("At") blinks with a half-period of BLINK_DIV cycles
//   undefined - no blink counter is built and code 1 shows "At" steadily
//
// Parameters:
//   REFRESH_DIV - cycles each digit stays lit before the scan advances (>=2)
//   BLINK_DIV   - cycles per blink half-period
//   ERR_HOLD    - cycles an error message is held after the last code 5 (>=1)
// Ports:
//   clk   - system clock, rising edge
//   clr   - asynchronous active-high reset
//   DispA - player A status code
//   DispB - player B status code
//   seg   - segments {g,f,e,d,c,b,a}, active-low
//   an    - digit enables, active-low, an[3] is the leftmost digit
//   dp    - decimal point, active-low, always off
module battleship_disp_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000,
  parameter int ERR_HOLD    = 100000000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [2:0] DispA,
  input  logic [2:0] DispB,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int ERR_W = $clog2(ERR_HOLD + 1);

  if (REFRESH_DIV < 2 || BLINK_DIV < 1 || ERR_HOLD < 1) begin : g_bad_param
    $error("battleship_disp_ctrl: REFRESH_DIV>=2, BLINK_DIV>=1, ERR_HOLD>=1 required");
  end

  typedef enum logic [3:0] {
    CH_BLANK,
    CH_L,
    CH_D,
    CH_A,
    CH_T,
    CH_DASH,
    CH_U,
    CH_P,
    CH_N,
    CH_E,
    CH_R
  } glyph_t;

  logic [2:0]       code_a;
  logic [2:0]       code_b;
  logic [PRE_W-1:0] prescale;
  logic [1:0]       idx;
  logic [ERR_W-1:0] err_a;
  logic [ERR_W-1:0] err_b;
  logic             blink;
  glyph_t           lit_char;

  // One character of a player's message. Error stretch beats blink
  // blanking, which beats the plain code map.
  function automatic glyph_t msg_char(input logic [2:0] code, input logic err_on,
                                      input logic blank_on, input logic right_side);
    glyph_t ch;
    ch = CH_BLANK;
    if (err_on) begin
      ch = right_side ? CH_R : CH_E;
    end else if (blank_on) begin
      ch = CH_BLANK;
    end else begin
      case (code)
        3'd0:    ch = right_side ? CH_D : CH_L;
        3'd1:    ch = right_side ? CH_T : CH_A;
        3'd2:    ch = CH_DASH;
        3'd3:    ch = right_side ? CH_P : CH_U;
        3'd4:    ch = right_side ? CH_N : CH_D;
        3'd5:    ch = right_side ? CH_R : CH_E;
        default: ch = CH_BLANK;
      endcase
    end
    return ch;
  endfunction

  // Active-high segment set {g,f,e,d,c,b,a} for each glyph.
  function automatic logic [6:0] glyph_on(input glyph_t ch);
    logic [6:0] s;
    case (ch)
      CH_L:    s = 7'b0111000;
      CH_D:    s = 7'b1011110;
      CH_A:    s = 7'b1110111;
      CH_T:    s = 7'b1111000;
      CH_DASH: s = 7'b1000000;
      CH_U:    s = 7'b0111110;
      CH_P:    s = 7'b1110011;
      CH_N:    s = 7'b1010100;
      CH_E:    s = 7'b1111001;
      CH_R:    s = 7'b1010000;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Input stage: all decoding works from these registered codes.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      code_a <= 3'd0;
      code_b <= 3'd0;
    end else begin
      code_a <= DispA;
      code_b <= DispB;
    end
  end

  // Scan prescaler; the digit index advances once per REFRESH_DIV cycles.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prescale <= '0;
      idx      <= 2'd0;
    end else if (prescale == PRE_W'(REFRESH_DIV - 1)) begin
      prescale <= '0;
      idx      <= idx + 2'd1;
    end else begin
      prescale <= prescale + PRE_W'(1);
    end
  end

  // Error stretch: a code 5 (re)loads the hold, otherwise it drains to 0.
  // Loading takes priority, so a fresh error never gets cut short.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      err_a <= '0;
      err_b <= '0;
    end else begin
      if (code_a == 3'd5) begin
        err_a <= ERR_W'(ERR_HOLD);
      end else if (err_a != '0) begin
        err_a <= err_a - ERR_W'(1);
      end
      if (code_b == 3'd5) begin
        err_b <= ERR_W'(ERR_HOLD);
      end else if (err_b != '0) begin
        err_b <= err_b - ERR_W'(1);
      end
    end
  end

`ifdef BSDISP_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt;

  // Free-running blink phase, toggling every BLINK_DIV cycles.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end
`else
  assign blink = 1'b0;
`endif

  // Pick the character for the digit currently being scanned.
  always_comb begin
    lit_char = CH_BLANK;
    case (idx)
      2'd3:    lit_char = msg_char(code_a, err_a != '0, (code_a == 3'd1) && blink, 1'b0);
      2'd2:    lit_char = msg_char(code_a, err_a != '0, (code_a == 3'd1) && blink, 1'b1);
      2'd1:    lit_char = msg_char(code_b, err_b != '0, (code_b == 3'd1) && blink, 1'b0);
      default: lit_char = msg_char(code_b, err_b != '0, (code_b == 3'd1) && blink, 1'b1);
    endcase
  end

  // Segments and enables share one register stage so a digit never
  // shows its neighbour's pattern during the switch-over.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      seg <= 7'b1111111;
      an  <= 4'b1111;
    end else begin
      seg <= ~glyph_on(lit_char);
      an  <= ~(4'b0001 << idx);
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_battleship_disp_ctrl.sv
// Testbench for battleship_disp_ctrl with small dividers so the scan,
// blink and error hold all turn over many times in a short run.
module tb_battleship_disp_ctrl;

  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 32;
  localparam int ERR_HOLD    = 20;
`ifdef BSDISP_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic [2:0] DispA;
  logic [2:0] DispB;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int compared;
  int mismatched;

  // Reference state: edges since reset release, the codes sampled on the
  // previous edge, and the edge on which each player last presented a 5.
  int         n;
  logic [2:0] prev_a;
  logic [2:0] prev_b;
  int         last5_a;
  int         last5_b;

  typedef struct {
    logic [2:0]  da;
    logic [2:0]  db;
    logic [27:0] exp_segs;
  } tvec_t;

  tvec_t tbl[6];

  battleship_disp_ctrl #(
    .REFRESH_DIV(REFRESH_DIV),
    .BLINK_DIV  (BLINK_DIV),
    .ERR_HOLD   (ERR_HOLD)
  ) dut (
    .clk  (clk),
    .clr  (clr),
    .DispA(DispA),
    .DispB(DispB),
    .seg  (seg),
    .an   (an),
    .dp   (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] msg_for(input logic [2:0] code, input bit err_on,
                                          input bit blink_on);
    if (err_on) return "Er";
    if (blink_on && code == 3'd1) return "  ";
    case (code)
      3'd0:    return "Ld";
      3'd1:    return "At";
      3'd2:    return "--";
      3'd3:    return "UP";
      3'd4:    return "dn";
      3'd5:    return "Er";
      default: return "  ";
    endcase
  endfunction

  function automatic logic [6:0] char_seg(input logic [7:0] c);
    case (c)
      "L":     return 7'b1000111;
      "d":     return 7'b0100001;
      "A":     return 7'b0001000;
      "t":     return 7'b0000111;
      "-":     return 7'b0111111;
      "U":     return 7'b1000001;
      "P":     return 7'b0001100;
      "n":     return 7'b0101011;
      "E":     return 7'b0000110;
      "r":     return 7'b0101111;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic compareField(input string name, input logic [6:0] got, input logic [6:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s at edge %0d: got %b, want %b", name, n, got, want);
    end
  endtask

  task automatic checkOutput();
    int         p;
    int         d;
    bit         blink_on;
    bit         err_a_on;
    bit         err_b_on;
    logic [15:0] msg_a;
    logic [15:0] msg_b;
    logic [7:0]  ch;
    logic [3:0]  one;
    p        = n - 1;
    d        = (p / REFRESH_DIV) % 4;
    blink_on = BLINK_EN && ((p / BLINK_DIV) % 2 == 1);
    err_a_on = (p - last5_a >= 1) && (p - last5_a <= ERR_HOLD);
    err_b_on = (p - last5_b >= 1) && (p - last5_b <= ERR_HOLD);
    msg_a    = msg_for(prev_a, err_a_on, blink_on);
    msg_b    = msg_for(prev_b, err_b_on, blink_on);
    case (d)
      3:       ch = msg_a[15:8];
      2:       ch = msg_a[7:0];
      1:       ch = msg_b[15:8];
      default: ch = msg_b[7:0];
    endcase
    one = 4'b0001;
    compareField("an", {3'b000, an}, {3'b000, ~(one << d)});
    compareField("seg", seg, char_seg(ch));
    compareField("dp", {6'b0, dp}, 7'd1);
  endtask

  task automatic applyStimulus(input logic [2:0] da, input logic [2:0] db);
    @(negedge clk);
    DispA = da;
    DispB = db;
    @(posedge clk);
    n++;
    #1;
    checkOutput();
    prev_a = da;
    prev_b = db;
    if (da == 3'd5) last5_a = n;
    if (db == 3'd5) last5_b = n;
  endtask

  task automatic applyReset(input string tag);
    clr = 1'b1;
    #1;
    compareField({tag, "_an"}, {3'b000, an}, 7'b0001111);
    compareField({tag, "_seg"}, seg, 7'b1111111);
    compareField({tag, "_dp"}, {6'b0, dp}, 7'd1);
    @(posedge clk);
    #1;
    compareField({tag, "_an_held"}, {3'b000, an}, 7'b0001111);
    @(posedge clk);
    #3;
    clr     = 1'b0;
    n       = 0;
    prev_a  = 3'd0;
    prev_b  = 3'd0;
    last5_a = -100000;
    last5_b = -100000;
  endtask

  initial begin
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] pa;
    logic [2:0] pb;
    int         d;

    compared   = 0;
    mismatched = 0;
    clr        = 1'b1;
    DispA      = 3'd0;
    DispB      = 3'd0;
    n          = 0;

    // Digit order in exp_segs: {an[3], an[2], an[1], an[0]}.
    tbl[0] = '{da: 3'd0, db: 3'd2, exp_segs: {7'b1000111, 7'b0100001, 7'b0111111, 7'b0111111}};
    tbl[1] = '{da: 3'd3, db: 3'd4, exp_segs: {7'b1000001, 7'b0001100, 7'b0100001, 7'b0101011}};
    tbl[2] = '{da: 3'd6, db: 3'd0, exp_segs: {7'b1111111, 7'b1111111, 7'b1000111, 7'b0100001}};
    tbl[3] = '{da: 3'd2, db: 3'd3, exp_segs: {7'b0111111, 7'b0111111, 7'b1000001, 7'b0001100}};
    tbl[4] = '{da: 3'd4, db: 3'd7, exp_segs: {7'b0100001, 7'b0101011, 7'b1111111, 7'b1111111}};
    tbl[5] = '{da: 3'd5, db: 3'd5, exp_segs: {7'b0000110, 7'b0101111, 7'b0000110, 7'b0101111}};

    $display("[TB] reset and decode table");
    applyReset("reset");
    for (int i = 0; i < 6; i++) begin
      for (int k = 1; k <= 24; k++) begin
        applyStimulus(tbl[i].da, tbl[i].db);
        if (k >= 9) begin
          d = (n - 1) / REFRESH_DIV % 4;
          compareField("table_seg", seg, tbl[i].exp_segs[d*7 +: 7]);
        end
      end
    end

    $display("[TB] single error pulse on B");
    applyReset("reset2");
    applyStimulus(3'd2, 3'd5);
    for (int k = 0; k < 40; k++) applyStimulus(3'd2, 3'd1);

    $display("[TB] error pulse extended by a second pulse");
    for (int k = 0; k < 10; k++) applyStimulus(3'd0, 3'd1);
    applyStimulus(3'd0, 3'd5);
    for (int k = 0; k < 9; k++) applyStimulus(3'd0, 3'd1);
    applyStimulus(3'd0, 3'd5);
    for (int k = 0; k < 40; k++) applyStimulus(3'd0, 3'd1);

    $display("[TB] blink on player A");
    applyReset("reset3");
    for (int k = 0; k < 140; k++) applyStimulus(3'd1, 3'd0);

    $display("[TB] reset during an error hold");
    applyStimulus(3'd5, 3'd0);
    for (int k = 0; k < 5; k++) applyStimulus(3'd2, 3'd0);
    #2;
    applyReset("midreset");
    for (int k = 0; k < 16; k++) begin
      applyStimulus(3'd2, 3'd0);
      if (n >= 9) compareField("midreset_dash", seg, 7'b0111111);
    end

    $display("[TB] random codes");
    ra = 3'd0;
    rb = 3'd0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) ra = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) rb = 3'($urandom_range(0, 7));
      pa = ra;
      pb = rb;
      if ($urandom_range(0, 39) == 0) pa = 3'd5;
      if ($urandom_range(0, 39) == 0) pb = 3'd5;
      applyStimulus(pa, pb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
